svi_bus_rx_checker: RTL and testbench
=====================================

// Module: svi_bus_rx_checker
// PURPOSE
//  Receiving end of the 8-bit interface bus x driven by the top-level interface driver
//  (static word 8'h55). Samples the bus every i_clk and locks onto the expected word.
//  Flags and counts mismatches, and buffers mismatching samples in a small FIFO.
//  The FIFO is drained by a valid/ready consumer (debug/trace logic).
// PARAMETERS
//  W          8      bus width
//  EXP_WORD   8'h55  expected bus value
//  LOCK_CNT   4      consecutive matches needed to lock (1..15)
//  ERR_MAX    3      consecutive mismatches in TRACK that force ERROR (1..15)
//  FIFO_DEPTH 4      mismatch capture FIFO depth (power of 2, >=2)
// PORTS
//  i_clk        in   1          sole clock, rising edge
//  i_rst_n      in   1          synchronous reset, active-low
//  u_I_x        in   W          interface bus being monitored
//  o_locked     out  1          1 while state==TRACK
//  o_error      out  1          1 while state==ERROR
//  o_err_cnt    out  16         total mismatches seen in TRACK; saturates at 16'hFFFF
//  o_cap_valid  out  1          FIFO not empty
//  o_cap_data   out  W          FIFO head (mismatching sample)
//  i_cap_ready  in   1          consumer pop strobe (pop when valid&ready)
//  o_cap_ovf    out  1          sticky: a capture was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (i_rst_n==0 at a rising edge): state=IDLE; all counters 0; FIFO empty;
//    every output 0. Reset mid-operation discards FIFO contents and counts.
//  - u_I_x is registered once (s_q). All decisions use s_q, so 1 cycle of sample latency.
//    match = (s_q == EXP_WORD).
//  - FSM:
//    IDLE: go to ACQ the first cycle after reset deasserts.
//    ACQ: match -> mcnt++; mismatch -> mcnt=0.
//      mcnt reaching LOCK_CNT -> TRACK, with o_locked=1 from the next cycle.
//    TRACK: mismatch -> ecnt++, o_err_cnt++ (saturating), push s_q into FIFO.
//      match -> ecnt=0.
//      ecnt reaching ERR_MAX -> ERROR.
//    ERROR: behaviour set by the macro (see CONFIGURATION). No captures in ERROR.
//  - Lock latency: a clean bus from reset asserts o_locked exactly 1+1+LOCK_CNT cycles
//    after reset deasserts (IDLE cycle, sample register, LOCK_CNT matches).
//  - The mismatch that drives ecnt to ERR_MAX is still counted and captured.
//  - FIFO: registered head, so o_cap_data is stable while o_cap_valid=1 and i_cap_ready=0.
//    - Push when full: the sample is dropped, o_cap_ovf is set, o_err_cnt still increments.
//    - Simultaneous push and pop when full: both happen (no overflow).
//    - Simultaneous push and pop when empty: the push lands and o_cap_valid=1 next cycle.
//    - Read and write pointers wrap modulo FIFO_DEPTH.
//      An extra pointer bit distinguishes full from empty.
//  - o_err_cnt holds at 16'hFFFF and never wraps.
// CONFIGURATION
//  SVI_RX_AUTO_RELOCK_EN
//   defined: ERROR clears ecnt and mcnt and goes to ACQ the next cycle. o_error pulses
//     for 1 cycle. o_err_cnt and the FIFO are kept.
//   undefined: ERROR is sticky until reset, o_error stays 1, and the bus is ignored.
// TESTING
//  1. Bus=8'h55 constant from reset, LOCK_CNT=4
//     -> o_locked rises 6 cycles after i_rst_n rises; o_err_cnt=0, o_cap_valid=0.
//  2. Locked, inject a single 8'hAA
//     -> o_err_cnt=1; o_cap_valid=1 with o_cap_data=8'hAA; o_locked stays 1.
//  3. Locked, inject 3 consecutive 8'h00
//     -> ERROR; o_err_cnt=3; 3 FIFO entries of 8'h00.
//     Macro defined: relock after 1+4 good samples. Undefined: o_error is stuck at 1.
//  4. i_cap_ready=0 and 5 isolated mismatches (8'h01..8'h05), each followed by 8'h55
//     -> FIFO holds 01..04, o_cap_ovf=1, o_err_cnt=5.
//     Then i_cap_ready=1 pops 01,02,03,04 in order.
//  5. ACQ with pattern 55,55,55,AA,55x4 -> lock is delayed; mcnt restarts after AA.
//     Full FIFO with push and pop in the same cycle -> no overflow.
//  6. Assert i_rst_n=0 while in TRACK with FIFO non-empty
//     -> next cycle all outputs 0 and the FIFO is empty.

Source files
------------

// File: rtl/svi_bus_rx_checker.sv
// Receive-side checker for the static interface bus: locks onto EXP_WORD, counts and captures mismatches.
// Optional feature macro: SVI_RX_AUTO_RELOCK_EN (ERROR auto-returns to ACQ instead of being sticky).
module svi_bus_rx_checker #(
  parameter int unsigned    W          = 8,
  parameter logic [W-1:0]   EXP_WORD   = W'(8'h55),
  parameter int unsigned    LOCK_CNT   = 4,
  parameter int unsigned    ERR_MAX    = 3,
  parameter int unsigned    FIFO_DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] u_I_x,
  output logic         o_locked,
  output logic         o_error,
  output logic [15:0]  o_err_cnt,
  output logic         o_cap_valid,
  output logic [W-1:0] o_cap_data,
  input  logic         i_cap_ready,
  output logic         o_cap_ovf
);

  localparam int unsigned CW  = 4;
  localparam int unsigned EW  = 16;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_s_q;
  logic [CW-1:0]  r_mcnt;
  logic [CW-1:0]  r_ecnt;
  logic [CW-1:0]  w_mcnt_nxt;
  logic [CW-1:0]  w_ecnt_nxt;
  logic [EW-1:0]  r_err_cnt;
  logic           r_locked;
  logic           r_error;
  logic           w_match;
  logic           w_cap_req;

  logic [W-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  w_wr_ptr_nxt;
  logic [PW-1:0]  w_rd_ptr_nxt;
  logic           r_cap_valid;
  logic [W-1:0]   r_cap_data;
  logic           r_cap_ovf;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic           w_valid_nxt;
  logic [W-1:0]   w_head_nxt;

  assign w_match = (r_s_q == EXP_WORD);

  // Next-state and counter update
  always_comb begin
    w_state_nxt = r_state;
    w_mcnt_nxt  = r_mcnt;
    w_ecnt_nxt  = r_ecnt;
    w_cap_req   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_ACQ;
        w_mcnt_nxt  = '0;
        w_ecnt_nxt  = '0;
      end
      ST_ACQ: begin
        if (r_mcnt == CW'(LOCK_CNT)) begin
          w_state_nxt = ST_TRACK;
          w_ecnt_nxt  = '0;
        end else if (w_match) begin
          w_mcnt_nxt = r_mcnt + CW'(1);
        end else begin
          w_mcnt_nxt = '0;
        end
      end
      ST_TRACK: begin
        if (w_match) begin
          w_ecnt_nxt = '0;
        end else begin
          w_cap_req  = 1'b1;
          w_ecnt_nxt = r_ecnt + CW'(1);
          if (r_ecnt == CW'(ERR_MAX - 1)) w_state_nxt = ST_ERROR;
        end
      end
      ST_ERROR: begin
`ifdef SVI_RX_AUTO_RELOCK_EN
        w_state_nxt = ST_ACQ;
        w_mcnt_nxt  = '0;
        w_ecnt_nxt  = '0;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pops take effect alongside a push, so a full FIFO can accept when drained the same cycle
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop        = r_cap_valid & i_cap_ready;
  assign w_push       = w_cap_req & (~w_full | w_pop);
  assign w_drop       = w_cap_req & w_full & ~w_pop;
  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  assign w_valid_nxt  = (w_wr_ptr_nxt != w_rd_ptr_nxt);

  // Head register tracks the slot the read pointer will address, bypassing a same-cycle write
  always_comb begin
    w_head_nxt = r_cap_data;
    if (w_valid_nxt) begin
      if (w_push && (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0])) w_head_nxt = r_s_q;
      else                                                       w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_s_q       <= '0;
      r_mcnt      <= '0;
      r_ecnt      <= '0;
      r_err_cnt   <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
      r_cap_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s_q       <= u_I_x;
      r_mcnt      <= w_mcnt_nxt;
      r_ecnt      <= w_ecnt_nxt;
      r_locked    <= (w_state_nxt == ST_TRACK);
      r_error     <= (w_state_nxt == ST_ERROR);
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_cap_valid <= w_valid_nxt;
      r_cap_data  <= w_head_nxt;
      if (w_drop) r_cap_ovf <= 1'b1;
      if (w_cap_req && (r_err_cnt != {EW{1'b1}})) r_err_cnt <= r_err_cnt + EW'(1);
    end
  end

  // Storage needs no reset; validity is carried by the pointers
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_s_q;
  end

  assign o_locked    = r_locked;
  assign o_error     = r_error;
  assign o_err_cnt   = r_err_cnt;
  assign o_cap_valid = r_cap_valid;
  assign o_cap_data  = r_cap_data;
  assign o_cap_ovf   = r_cap_ovf;

endmodule

// File: tb/tb_svi_bus_rx_checker.sv
// Scoreboard bench for svi_bus_rx_checker: expected captures queued on stimulus, compared on pop.
module tb_svi_bus_rx_checker;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] bus;
  logic         cap_ready;
  logic         locked;
  logic         error;
  logic [15:0]  err_cnt;
  logic         cap_valid;
  logic [W-1:0] cap_data;
  logic         cap_ovf;

  int           n_chk  = 0;
  int           n_pass = 0;
  logic [W-1:0] exp_q [$];
  int           exp_err;
  logic         exp_ovf;
  logic [W-1:0] pat [8];
  int           n;

  always #5 clk = ~clk;

  svi_bus_rx_checker dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .u_I_x       (bus),
    .o_locked    (locked),
    .o_error     (error),
    .o_err_cnt   (err_cnt),
    .o_cap_valid (cap_valid),
    .o_cap_data  (cap_data),
    .i_cap_ready (cap_ready),
    .o_cap_ovf   (cap_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else             n_pass++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_error"},  32'(error), 32'd0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_valid"},  32'(cap_valid), 32'd0);
    chk({tag, "_data"},   32'(cap_data), 32'd0);
    chk({tag, "_ovf"},    32'(cap_ovf), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick();
    chk_zero(tag);
    exp_q.delete();
    exp_err = 0;
    exp_ovf = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wait_lock(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!locked && cycles < 40);
  endtask

  // One isolated mismatch followed by a good word, with the expected capture/overflow modelled
  task automatic mismatch(input logic [W-1:0] v);
    bus = v;
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
    else                      exp_ovf = 1'b1;
    exp_err++;
    tick();
    bus = W'(8'h55);
    tick();
  endtask

  task automatic drain();
    int guard;
    logic [W-1:0] e;
    guard = 0;
    cap_ready = 1'b1;
    while (cap_valid && guard < 20) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cap_data", 32'(cap_data), 32'(e));
      end else begin
        chk("cap_extra", 32'(cap_valid), 32'd0);
      end
      tick();
      guard++;
    end
    cap_ready = 1'b0;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(cap_valid), 32'd0);
  endtask

  initial begin
    pat = '{8'h55, 8'h55, 8'h55, 8'hAA, 8'h55, 8'h55, 8'h55, 8'h55};
    rst_n     = 1'b0;
    bus       = W'(8'h55);
    cap_ready = 1'b0;
    exp_err   = 0;
    exp_ovf   = 1'b0;

    // Clean bus from reset
    do_reset("rst0");
    wait_lock(n);
    chk("lock_lat", 32'(n), 32'd6);
    chk("t1_errcnt", 32'(err_cnt), 32'd0);
    chk("t1_valid", 32'(cap_valid), 32'd0);
    chk("t1_error", 32'(error), 32'd0);

    // Single mismatch while locked
    mismatch(W'(8'hAA));
    chk("t2_errcnt", 32'(err_cnt), 32'(exp_err));
    chk("t2_valid", 32'(cap_valid), 32'd1);
    chk("t2_data", 32'(cap_data), 32'h0AA);
    chk("t2_locked", 32'(locked), 32'd1);
    drain();

    // ERR_MAX consecutive mismatches
    for (int i = 0; i < 3; i++) begin
      bus = W'(8'h00);
      exp_q.push_back(W'(8'h00));
      exp_err++;
      tick();
    end
    bus = W'(8'h55);
    tick();
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_locked", 32'(locked), 32'd0);
    chk("t3_errcnt", 32'(err_cnt), 32'(exp_err));
    chk("t3_valid", 32'(cap_valid), 32'd1);
`ifdef SVI_RX_AUTO_RELOCK_EN
    tick();
    chk("t3_err_pulse", 32'(error), 32'd0);
    wait_lock(n);
    chk("t3_relock", 32'(locked), 32'd1);
`else
    bus = W'(8'h00);
    repeat (4) tick();
    bus = W'(8'h55);
    tick();
    chk("t3_sticky", 32'(error), 32'd1);
    chk("t3_ignored", 32'(err_cnt), 32'(exp_err));
    chk("t3_still_unlocked", 32'(locked), 32'd0);
`endif
    chk("t3_kept", 32'(err_cnt), 32'(exp_err));
    drain();

    // Reset mid-operation, then a mismatch during acquisition delays lock
    do_reset("rst1");
    n = 0;
    do begin
      bus = (n < 8) ? pat[n] : W'(8'h55);
      tick();
      n++;
    end while (!locked && n < 40);
    chk("lock_delay", 32'(n), 32'd10);
    chk("t5_errcnt", 32'(err_cnt), 32'd0);

    // Fill the FIFO, then push and pop in the same cycle
    for (int v = 16; v < 20; v++) mismatch(W'(v));
    chk("t5_full_valid", 32'(cap_valid), 32'd1);
    chk("t5_full_head", 32'(cap_data), 32'h010);
    chk("t5_full_ovf", 32'(cap_ovf), 32'd0);
    bus = W'(8'h14);
    tick();
    cap_ready = 1'b1;
    if (exp_q.size() > 0) chk("t5_pp_head", 32'(cap_data), 32'(exp_q.pop_front()));
    exp_q.push_back(W'(8'h14));
    exp_err++;
    bus = W'(8'h55);
    tick();
    cap_ready = 1'b0;
    chk("t5_pp_ovf", 32'(cap_ovf), 32'd0);
    chk("t5_pp_head2", 32'(cap_data), 32'h011);
    chk("t5_pp_errcnt", 32'(err_cnt), 32'(exp_err));
    drain();

    // Overflow: five captures into a four-deep FIFO with no consumer
    for (int v = 1; v <= 5; v++) mismatch(W'(v));
    chk("t4_ovf", 32'(cap_ovf), 32'(exp_ovf));
    chk("t4_errcnt", 32'(err_cnt), 32'(exp_err));
    chk("t4_head", 32'(cap_data), 32'h001);
    chk("t4_locked", 32'(locked), 32'd1);
    drain();
    chk("t4_ovf_sticky", 32'(cap_ovf), 32'd1);

    // Reset while tracking with FIFO non-empty
    mismatch(W'(8'h77));
    chk("t6_valid", 32'(cap_valid), 32'd1);
    do_reset("rst2");
    wait_lock(n);
    chk("t6_relock_lat", 32'(n), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
